// File: rtl/video_timing_pkg.sv
// Shared definitions for the video timing / test-pattern generator:
// pattern mode encodings, colour-bar table and standard resolution presets.
package video_timing_pkg;

    typedef enum logic [2:0] {
        MODE_SOLID = 3'd0,
        MODE_BARS  = 3'd1,
        MODE_GRID  = 3'd2,
        MODE_GRAD  = 3'd3,
        MODE_CHECK = 3'd4
    } mode_e;

    localparam int unsigned NUM_BARS = 8;

    // {R,G,B} on/off per bar, index 0 (leftmost) in the low slot
    localparam logic [NUM_BARS-1:0][2:0] BAR_TABLE = {
        3'b000,  // black
        3'b001,  // blue
        3'b100,  // red
        3'b101,  // magenta
        3'b010,  // green
        3'b011,  // cyan
        3'b110,  // yellow
        3'b111   // white
    };

    typedef struct packed {
        int unsigned h_active;
        int unsigned h_front;
        int unsigned h_sync;
        int unsigned h_back;
        int unsigned v_active;
        int unsigned v_front;
        int unsigned v_sync;
        int unsigned v_back;
    } timing_t;

    localparam timing_t TIMING_640X480   = '{640,  16,  96,  48,  480,  10, 2, 33};
    localparam timing_t TIMING_800X600   = '{800,  40,  128, 88,  600,  1,  4, 23};
    localparam timing_t TIMING_1024X768  = '{1024, 24,  136, 160, 768,  3,  6, 29};
    localparam timing_t TIMING_1280X720  = '{1280, 110, 40,  220, 720,  5,  5, 20};
    localparam timing_t TIMING_1280X1024 = '{1280, 48,  112, 248, 1024, 1,  3, 38};
    localparam timing_t TIMING_1680X1050 = '{1680, 104, 176, 280, 1050, 3,  6, 30};
    localparam timing_t TIMING_1920X1080 = '{1920, 88,  44,  148, 1080, 4,  5, 36};

    function automatic logic [2:0] bar_color(input logic [2:0] idx);
        return BAR_TABLE[idx];
    endfunction

endpackage

// File: rtl/video_timing_core.sv
// Raster counters with combinational active-video and sync decode for the
// current counter state; the parent registers everything for alignment.
module video_timing_core #(
    parameter int unsigned H_ACTIVE      = 640,
    parameter int unsigned H_FRONT_PORCH = 16,
    parameter int unsigned H_SYNC_TIME   = 96,
    parameter int unsigned H_BACK_PORCH  = 48,
    parameter int unsigned V_ACTIVE      = 480,
    parameter int unsigned V_FRONT_PORCH = 10,
    parameter int unsigned V_SYNC_TIME   = 2,
    parameter int unsigned V_BACK_PORCH  = 33,
    parameter bit          H_POLARITY    = 1'b0,
    parameter bit          V_POLARITY    = 1'b0,
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT_PORCH + H_SYNC_TIME + H_BACK_PORCH,
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT_PORCH + V_SYNC_TIME + V_BACK_PORCH,
    localparam int unsigned XW      = $clog2(H_TOTAL),
    localparam int unsigned YW      = $clog2(V_TOTAL)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    output logic [XW-1:0] o_cnt_h,
    output logic [YW-1:0] o_cnt_v,
    output logic          o_de,
    output logic          o_hs,
    output logic          o_vs,
    output logic          o_origin,
    output logic          o_line_end,
    output logic          o_frame_end
);

    localparam logic [XW-1:0] H_LAST     = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] H_ACT_END  = XW'(H_ACTIVE);
    localparam logic [XW-1:0] HS_START   = XW'(H_ACTIVE + H_FRONT_PORCH);
    localparam logic [XW-1:0] HS_END     = XW'(H_ACTIVE + H_FRONT_PORCH + H_SYNC_TIME);
    localparam logic [YW-1:0] V_LAST     = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] V_ACT_END  = YW'(V_ACTIVE);
    localparam logic [YW-1:0] VS_START   = YW'(V_ACTIVE + V_FRONT_PORCH);
    localparam logic [YW-1:0] VS_END     = YW'(V_ACTIVE + V_FRONT_PORCH + V_SYNC_TIME);

    logic [XW-1:0] cnt_h_q, cnt_h_d;
    logic [YW-1:0] cnt_v_q, cnt_v_d;
    logic          line_end, frame_end;
    logic          hs_act, vs_act;

    always_comb begin
        line_end  = (cnt_h_q == H_LAST);
        frame_end = line_end && (cnt_v_q == V_LAST);
        cnt_h_d   = cnt_h_q;
        cnt_v_d   = cnt_v_q;
        if (!i_en) begin
            cnt_h_d = '0;
            cnt_v_d = '0;
        end else if (line_end) begin
            cnt_h_d = '0;
            cnt_v_d = frame_end ? '0 : cnt_v_q + 1'b1;
        end else begin
            cnt_h_d = cnt_h_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_h_q <= '0;
            cnt_v_q <= '0;
        end else begin
            cnt_h_q <= cnt_h_d;
            cnt_v_q <= cnt_v_d;
        end
    end

    // vs depends only on cnt_v, so it can only move when cnt_h returns to 0
    always_comb begin
        hs_act      = (cnt_h_q >= HS_START) && (cnt_h_q < HS_END);
        vs_act      = (cnt_v_q >= VS_START) && (cnt_v_q < VS_END);
        o_de        = (cnt_h_q < H_ACT_END) && (cnt_v_q < V_ACT_END);
        o_hs        = hs_act ? H_POLARITY : ~H_POLARITY;
        o_vs        = vs_act ? V_POLARITY : ~V_POLARITY;
        o_origin    = (cnt_h_q == '0) && (cnt_v_q == '0);
        o_line_end  = line_end;
        o_frame_end = frame_end;
        o_cnt_h     = cnt_h_q;
        o_cnt_v     = cnt_v_q;
    end

endmodule

// File: rtl/video_timing_pattern_gen.sv
// Video timing and test-pattern source: registers sync, DE, x/y and a
// pattern RGB all from the same raster counter state.
module video_timing_pattern_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE      = 640,
    parameter int unsigned H_FRONT_PORCH = 16,
    parameter int unsigned H_SYNC_TIME   = 96,
    parameter int unsigned H_BACK_PORCH  = 48,
    parameter int unsigned V_ACTIVE      = 480,
    parameter int unsigned V_FRONT_PORCH = 10,
    parameter int unsigned V_SYNC_TIME   = 2,
    parameter int unsigned V_BACK_PORCH  = 33,
    parameter bit          H_POLARITY    = 1'b0,
    parameter bit          V_POLARITY    = 1'b0,
    parameter int unsigned COLOR_W       = 8,
    parameter int unsigned GRID_STEP     = 20,
    parameter int unsigned CHECKER_LOG2  = 5,
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT_PORCH + H_SYNC_TIME + H_BACK_PORCH,
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT_PORCH + V_SYNC_TIME + V_BACK_PORCH,
    localparam int unsigned XW      = $clog2(H_TOTAL),
    localparam int unsigned YW      = $clog2(V_TOTAL)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic [2:0]           i_mode,
    input  logic [3*COLOR_W-1:0] i_solid_rgb,
    output logic [COLOR_W-1:0]   o_red_data,
    output logic [COLOR_W-1:0]   o_gre_data,
    output logic [COLOR_W-1:0]   o_blu_data,
    output logic                 o_h_sync,
    output logic                 o_v_sync,
    output logic                 o_data_en,
    output logic                 o_frame_start,
    output logic [XW-1:0]        o_x,
    output logic [YW-1:0]        o_y
);

    localparam int unsigned   PW        = 3 * COLOR_W;
    localparam int unsigned   GW        = $clog2(GRID_STEP + 1);
    localparam logic [XW-1:0] BAR_LAST  = XW'(H_ACTIVE / NUM_BARS - 1);
    localparam logic [GW-1:0] GRID_LAST = GW'(GRID_STEP - 1);
    localparam logic [XW-1:0] X_LAST    = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST    = YW'(V_ACTIVE - 1);

    logic [XW-1:0] cnt_h;
    logic [YW-1:0] cnt_v;
    logic          de, hs, vs, origin, line_end, frame_end;

    video_timing_core #(
        .H_ACTIVE      (H_ACTIVE),
        .H_FRONT_PORCH (H_FRONT_PORCH),
        .H_SYNC_TIME   (H_SYNC_TIME),
        .H_BACK_PORCH  (H_BACK_PORCH),
        .V_ACTIVE      (V_ACTIVE),
        .V_FRONT_PORCH (V_FRONT_PORCH),
        .V_SYNC_TIME   (V_SYNC_TIME),
        .V_BACK_PORCH  (V_BACK_PORCH),
        .H_POLARITY    (H_POLARITY),
        .V_POLARITY    (V_POLARITY)
    ) u_core (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_en        (i_en),
        .o_cnt_h     (cnt_h),
        .o_cnt_v     (cnt_v),
        .o_de        (de),
        .o_hs        (hs),
        .o_vs        (vs),
        .o_origin    (origin),
        .o_line_end  (line_end),
        .o_frame_end (frame_end)
    );

    logic [2:0]    mode_q, mode_d, mode_eff;
    logic [PW-1:0] solid_q, solid_d, solid_eff;
    logic [7:0]    frame_q, frame_d;
    logic [XW-1:0] bar_px_q, bar_px_d;
    logic [2:0]    bar_idx_q, bar_idx_d;
    logic [GW-1:0] gx_q, gx_d, gy_q, gy_d;

    // Mode/colour are only taken at the frame origin so a frame never tears;
    // the origin pixel itself already uses the newly sampled values.
    always_comb begin
        mode_eff  = origin ? i_mode : mode_q;
        solid_eff = origin ? i_solid_rgb : solid_q;
        mode_d    = mode_q;
        solid_d   = solid_q;
        if (i_en && origin) begin
            mode_d  = i_mode;
            solid_d = i_solid_rgb;
        end
        frame_d = (i_en && frame_end) ? frame_q + 8'd1 : frame_q;
    end

    // Step counters track cnt_h/cnt_v so bars and grid need no divider or modulo
    always_comb begin
        bar_px_d  = bar_px_q + 1'b1;
        bar_idx_d = bar_idx_q;
        if (!i_en || line_end) begin
            bar_px_d  = '0;
            bar_idx_d = '0;
        end else if (bar_px_q == BAR_LAST && bar_idx_q != 3'd7) begin
            bar_px_d  = '0;
            bar_idx_d = bar_idx_q + 3'd1;
        end

        gx_d = (gx_q == GRID_LAST) ? '0 : gx_q + 1'b1;
        gy_d = gy_q;
        if (!i_en || line_end) begin
            gx_d = '0;
        end
        if (!i_en || frame_end) begin
            gy_d = '0;
        end else if (line_end) begin
            gy_d = (gy_q == GRID_LAST) ? '0 : gy_q + 1'b1;
        end
    end

    logic [2:0]    bar_c;
    logic          grid_black;
    logic [PW-1:0] pix;

    always_comb begin
        bar_c      = bar_color(bar_idx_q);
        grid_black = (gx_q == '0) || (gy_q == '0) || (cnt_h == X_LAST) || (cnt_v == Y_LAST);
        pix        = '0;
        case (mode_eff)
            MODE_SOLID: pix = solid_eff;
            MODE_BARS:  pix = {{COLOR_W{bar_c[2]}}, {COLOR_W{bar_c[1]}}, {COLOR_W{bar_c[0]}}};
            MODE_GRID:  pix = grid_black ? '0 : '1;
            MODE_GRAD:  pix = {COLOR_W'(cnt_h), COLOR_W'(cnt_v), COLOR_W'(frame_q)};
            MODE_CHECK: pix = (cnt_h[CHECKER_LOG2] ^ cnt_v[CHECKER_LOG2]) ? '1 : '0;
            default:    pix = '0;
        endcase
    end

    logic          de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [PW-1:0] rgb_q, rgb_d;

    always_comb begin
        de_d  = 1'b0;
        hs_d  = ~H_POLARITY;
        vs_d  = ~V_POLARITY;
        fs_d  = 1'b0;
        x_d   = '0;
        y_d   = '0;
        rgb_d = '0;
        if (i_en) begin
            de_d  = de;
            hs_d  = hs;
            vs_d  = vs;
            fs_d  = origin;
            x_d   = cnt_h;
            y_d   = cnt_v;
            rgb_d = de ? pix : '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mode_q    <= MODE_SOLID;
            solid_q   <= '0;
            frame_q   <= '0;
            bar_px_q  <= '0;
            bar_idx_q <= '0;
            gx_q      <= '0;
            gy_q      <= '0;
            de_q      <= 1'b0;
            hs_q      <= ~H_POLARITY;
            vs_q      <= ~V_POLARITY;
            fs_q      <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            rgb_q     <= '0;
        end else begin
            mode_q    <= mode_d;
            solid_q   <= solid_d;
            frame_q   <= frame_d;
            bar_px_q  <= bar_px_d;
            bar_idx_q <= bar_idx_d;
            gx_q      <= gx_d;
            gy_q      <= gy_d;
            de_q      <= de_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            fs_q      <= fs_d;
            x_q       <= x_d;
            y_q       <= y_d;
            rgb_q     <= rgb_d;
        end
    end

    assign o_red_data    = rgb_q[3*COLOR_W-1:2*COLOR_W];
    assign o_gre_data    = rgb_q[2*COLOR_W-1:COLOR_W];
    assign o_blu_data    = rgb_q[COLOR_W-1:0];
    assign o_h_sync      = hs_q;
    assign o_v_sync      = vs_q;
    assign o_data_en     = de_q;
    assign o_frame_start = fs_q;
    assign o_x           = x_q;
    assign o_y           = y_q;

endmodule

// File: doc/video_timing_pattern_gen.md
Name: video_timing_pattern_gen

Overview:
Parametrised video timing and test-pattern source for the LVDS display path. It produces h_sync, v_sync and data_en for any resolution set by parameters, plus registered RGB of selectable colour depth. Five runtime-selectable patterns are available, and every output is cycle-aligned. It sits ahead of the LVDS serializer and replaces fixed-resolution generators.

Parameters:
H_ACTIVE, 640, active pixels per line
H_FRONT_PORCH, 16, pixels after active
H_SYNC_TIME, 96, h_sync width in pixels
H_BACK_PORCH, 48, pixels after sync
V_ACTIVE, 480, active lines
V_FRONT_PORCH, 10, lines after active
V_SYNC_TIME, 2, v_sync width in lines
V_BACK_PORCH, 33, lines after sync
H_POLARITY, 0, sync active level (0 = active-low)
V_POLARITY, 0, sync active level (0 = active-low)
COLOR_W, 8, bits per colour channel (4..10)
GRID_STEP, 20, grid line spacing in pixels and lines
CHECKER_LOG2, 5, checker square size = 2^CHECKER_LOG2

Ports:
i_clk  in  1  pixel clock
i_rst  in  1  asynchronous active-high reset
i_en  in  1  run enable
i_mode  in  3  pattern select
i_solid_rgb  in  3*COLOR_W  {R,G,B} for solid mode
o_red_data  out  COLOR_W  red
o_gre_data  out  COLOR_W  green
o_blu_data  out  COLOR_W  blue
o_h_sync  out  1  horizontal sync
o_v_sync  out  1  vertical sync
o_data_en  out  1  active-video qualifier
o_frame_start  out  1  one-cycle pulse on first active pixel of each frame
o_x  out  clog2(H_TOTAL)  pixel x of current output
o_y  out  clog2(V_TOTAL)  line y of current output

Behaviour:
- One clock; reset is asynchronous and active-high.
- Totals: H_TOTAL = sum of the four H params; V_TOTAL likewise.
- Counters:
  - cnt_h runs 0..H_TOTAL-1 and wraps.
  - cnt_v increments when cnt_h wraps; it runs 0..V_TOTAL-1 and wraps.
  - Line order is active, front porch, sync, back porch, in that order.
- Decode:
  - de = cnt_h < H_ACTIVE and cnt_v < V_ACTIVE.
  - hs active when H_ACTIVE+H_FRONT_PORCH ≤ cnt_h < H_ACTIVE+H_FRONT_PORCH+H_SYNC_TIME.
  - vs active over the equivalent line range; it changes only when cnt_h == 0.
- Latency: every output is registered 1 cycle after its counter value. RGB, data_en, syncs, x and y all correspond to the same counter state, so there is no skew.
- Reset values:
  - Counters are 0.
  - o_h_sync = ~H_POLARITY and o_v_sync = ~V_POLARITY.
  - o_data_en, o_frame_start, RGB, o_x and o_y are 0.
  - Latched mode is 0; frame counter is 0.
- i_en low:
  - Counters clear to 0 synchronously and hold.
  - Outputs are driven to their reset values.
  - On i_en rising, the frame restarts at cnt_h = cnt_v = 0.
- Mode latch:
  - i_mode and i_solid_rgb are sampled only when cnt_h == 0 and cnt_v == 0.
  - A mid-frame change therefore takes effect on the next frame; no tearing.
- RGB outside active video is 0. Inside active video:
  - 0 solid: i_solid_rgb.
  - 1 colour bars: eight bars, each BAR_W = H_ACTIVE/8 wide, in order white, yellow, cyan, green, magenta, red, blue, black. The last bar absorbs the remainder. Bar index comes from a bar counter that resets at x = 0; no divider.
  - 2 grid: black where x or y is a multiple of GRID_STEP, or x = H_ACTIVE-1, or y = V_ACTIVE-1; white elsewhere. Use step counters, no modulo.
  - 3 gradient: R = x[COLOR_W-1:0], G = y[COLOR_W-1:0], B = frame counter low COLOR_W bits.
  - 4 checker: white when x[CHECKER_LOG2] XOR y[CHECKER_LOG2] is 1, else black.
  - 5-7 reserved: black.
- Full scale is all ones at COLOR_W.
- Frame counter: 8 bits, increments at each frame start, wraps 255 to 0.
- o_frame_start is high with o_x = 0, o_y = 0 and o_data_en = 1.
- Reset mid-frame: all state returns to reset values immediately, with no glitch beyond the asynchronous clear.

Decomposition:
- Package video_timing_pkg holds:
  - mode encodings: MODE_SOLID, MODE_BARS, MODE_GRID, MODE_GRAD, MODE_CHECK;
  - the bar colour table;
  - resolution preset localparams for 640x480, 800x600, 1024x768, 1280x720, 1280x1024, 1680x1050 and 1920x1080.
- Sub-module video_timing_core provides the h/v counters, sync/de decode and x/y. The pattern logic stays in the top.

Test Plan:
- Reset then i_en = 1 with defaults → from the first edge, o_data_en is high for 640 cycles, then low for 160. h_sync is low for exactly 96 cycles starting 656 cycles after the line's first DE. Period is 800 cycles.
- Full frame → o_v_sync is low for 2 lines, which are y 490-491. o_frame_start pulses once every 420000 cycles.
- Mode 1 → pixel x = 0 gives FFFFFF, x = 80 gives FFFF00, x = 639 gives 000000. All pixels are 0 while DE is low.
- Change i_mode 0→2 mid-frame → the current frame stays solid, and the grid appears from the next o_frame_start. Pixel (0,0) is black and (1,1) is white.
- Mode 3 over 257 frames → B at (0,0) increments per frame and wraps 255→0. Pixel (5,3) gives R = 5, G = 3.
- Assert i_rst mid-line, and separately drop i_en mid-frame → all outputs at reset values at once. Restart yields o_frame_start on the first cycle.
